mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the ALU result as either an effective address (loads/stores) or a pass-through result, and drives a single-port data-memory request/acknowledge interface.
- Performs byte-lane alignment for stores and sign/zero extension for loads.
- Registers the result toward writeback and stalls upstream while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported; byte-lane logic is fixed at 4 lanes.
- ADDR_WIDTH, 32, address width of the ALU result and dmem_addr.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction this cycle
- ex_flush  in  1  kill the instruction presented this cycle
- ex_alu_out  in  ADDR_WIDTH  ALU result: address for memory ops, result otherwise
- ex_store_data  in  DATA_WIDTH  rs2 value for stores
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_rd  in  5  destination register
- ex_reg_write  in  1  writeback enable
- stall  out  1  upstream must hold its inputs
- dmem_req  out  1  memory request
- dmem_we  out  1  write request
- dmem_addr  out  ADDR_WIDTH  word-aligned address
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  transaction complete; dmem_rdata valid this cycle
- dmem_rdata  in  DATA_WIDTH  read data, full word
- wb_valid  out  1  writeback bundle valid, one-cycle pulse per instruction
- wb_data  out  DATA_WIDTH  result to register file
- wb_rd  out  5  destination register
- wb_reg_write  out  1  writeback enable
- mem_err  out  1  one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset: the FSM goes to IDLE. All outputs are 0, including dmem_req, wb_valid, wb_reg_write and mem_err.
- Reset mid-transaction: dmem_req drops the next cycle. The transaction is abandoned, and a late dmem_ack is ignored.
- FSM states: IDLE and ACCESS. stall = (state == ACCESS), driven combinationally from state. Inputs are sampled only in IDLE.
- Input accepted: in IDLE with ex_valid=1 and ex_flush=0. Otherwise the input is ignored and wb_valid=0 next cycle.
- Non-memory instruction (mem_read=mem_write=0):
  - Next cycle: wb_valid=1, wb_data=ex_alu_out, and wb_rd/wb_reg_write taken from the inputs.
  - Latency 1, throughput 1 per cycle.
- Misaligned or illegal access: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {011,110,111} on a memory op.
  - No memory request is issued.
  - Next cycle: wb_valid=1, wb_reg_write=0, mem_err=1.
- Legal memory op: address, funct3, rd, reg_write and the aligned store data/be are latched, and the FSM goes to ACCESS.
- In ACCESS:
  - dmem_req=1 from registered state.
  - dmem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - dmem_we = stored mem_write.
  - All dmem_* outputs are held stable until dmem_ack.
- On dmem_ack in ACCESS, the FSM returns to IDLE, and next cycle wb_valid=1 with:
  - load: wb_data = extended read data, wb_reg_write = latched reg_write;
  - store: wb_reg_write=0.
- Memory-op latency: 1 cycle to enter ACCESS, plus N wait cycles until ack, plus 1 cycle to wb_valid. dmem_req is 0 in the cycle after ack.
- dmem_ack while in IDLE is ignored.
- ex_flush is ignored in ACCESS. An issued transaction always completes and writes back.
- Store alignment (k = addr[1:0]):
  - SB: be = 4'b0001 << k, wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011 << k, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
  - Loads: be = 4'b1111, wdata = 0.
- Load extraction: shifted = rdata >> (8*k).
  - B: sign-extend shifted[7:0].
  - BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0].
  - HU: zero-extend shifted[15:0].
  - W: rdata.
- wb_* outputs are registered. When wb_valid=0, wb_reg_write=0 and wb_data holds its last value.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - mem_state_t enum {IDLE, ACCESS};
  - store-lane and byte-enable helper functions.
- One natural combinational sub-module, mem_load_align, takes (rdata, addr[1:0], funct3) and produces the extended data. It is reusable by a future cache refill path.

Test Plan:
- Pass-through: ALU op, alu_out=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, dmem_req never asserted.
- SB: addr=0x103, data=0xAABBCCDD -> dmem_addr=0x100, be=4'b1000, wdata=0xDDDDDDDD. Ack after 3 wait cycles -> stall high 4 cycles, then wb_valid=1 with wb_reg_write=0.
- Loads from rdata=0x80FF7F01:
  - LB addr=0x202 -> wb_data=0xFFFFFFFF.
  - LBU addr=0x202 -> 0x000000FF.
  - LH addr=0x202 -> 0xFFFF80FF.
  - LHU addr=0x200 -> 0x00007F01.
  - LW addr=0x200 -> 0x80FF7F01.
- Misaligned: LW addr=0x101 -> no dmem_req, next cycle mem_err=1, wb_valid=1, wb_reg_write=0. The same occurs for SH at 0x103.
- Flush and stall:
  - ex_flush=1 with a valid load -> no request, wb_valid stays 0.
  - New ex_valid presented during ACCESS -> not accepted until IDLE, then processed exactly once.
- Reset mid-access: assert rst while dmem_req=1 -> dmem_req=0 next cycle, stall=0, and a following stray dmem_ack produces no wb_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings, FSM states
// and the store lane-placement helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // True when a memory op cannot be issued: unknown size code or a size/offset mismatch.
    function automatic logic access_illegal(input logic [2:0] funct3, input logic [1:0] k);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = k[0];
            F3_W:        bad = (k != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic is_store, input logic [2:0] funct3,
                                            input logic [1:0] k);
        logic [3:0] be;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (funct3[1:0])
                2'b00:   be = 4'b0001 << k;
                2'b01:   be = 4'b0011 << k;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicating the narrow datum across the word lets the byte enables pick the lane.
    function automatic logic [31:0] store_wdata(input logic is_store, input logic [2:0] funct3,
                                                input logic [31:0] data);
        logic [31:0] wdata;
        if (!is_store) begin
            wdata = 32'h0000_0000;
        end else begin
            case (funct3[1:0])
                2'b00:   wdata = {4{data[7:0]}};
                2'b01:   wdata = {2{data[15:0]}};
                default: wdata = data;
            endcase
        end
        return wdata;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-port data-memory request/acknowledge bus between the memory stage and the memory.
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_be;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword from a full read word and sign/zero extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Halfwords only ever reach here aligned, so addr_lo_i[1] alone selects the half.
    assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data_o = {24'h000000, lane_b};
            F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data_o = {16'h0000, lane_h};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the dmem bus, passes ALU results through,
// and registers one writeback bundle per accepted instruction.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_flush,
    input  logic [ADDR_WIDTH-1:0] ex_alu_out,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_write,
    output logic                  stall,
    mem_stage_if.master           dmem,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_write,
    output logic                  mem_err
);
    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [4:0]            rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic                  mem_err_q, mem_err_d;

    logic [DATA_WIDTH-1:0] load_data;
    logic                  is_mem;

    assign is_mem = ex_mem_read | ex_mem_write;

    mem_load_align u_load_align (
        .rdata_i   (dmem.dmem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            mem_err_q      <= mem_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        mem_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && !ex_flush) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_out;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                    end else if (access_illegal(ex_funct3, ex_alu_out[1:0])) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        mem_err_d  = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        addr_d      = ex_alu_out;
                        funct3_d    = ex_funct3;
                        rd_d        = ex_rd;
                        reg_write_d = ex_reg_write;
                        we_d        = ex_mem_write;
                        wdata_d     = store_wdata(ex_mem_write, ex_funct3, ex_store_data);
                        be_d        = store_be(ex_mem_write, ex_funct3, ex_alu_out[1:0]);
                    end
                end
            end
            ACCESS: begin
                // Flush is not looked at here: an issued transaction always writes back.
                if (dmem.dmem_ack) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (!we_q) begin
                        wb_data_d      = load_data;
                        wb_reg_write_d = reg_write_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall           = (state_q == ACCESS);
    assign dmem.dmem_req   = (state_q == ACCESS);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign mem_err      = mem_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized checks of mem_stage against an arithmetic reference model.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_flush, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [31:0] ex_alu_out, ex_store_data;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        stall, wb_valid, wb_reg_write, mem_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int vectors = 0;
    int miscompares = 0;

    mem_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();

    mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_flush      (ex_flush),
        .ex_alu_out    (ex_alu_out),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .stall         (stall),
        .dmem          (dmem_bus),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic ref_illegal(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned a;
        a = addr;
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic int unsigned ref_bytes(input logic [2:0] f3);
        int unsigned code;
        code = 32'(f3) % 4;
        if (code == 0) return 1;
        if (code == 1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned k,
                                             input logic [31:0] rdata);
        int unsigned sh, b, h;
        sh = rdata >> (8 * k);
        b  = sh % 256;
        h  = sh % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_be(input logic is_store, input logic [2:0] f3,
                                           input int unsigned k);
        int unsigned n, mask;
        if (!is_store) return 32'd15;
        n    = ref_bytes(f3);
        mask = ((32'd1 << n) - 1) << k;
        return mask % 16;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic is_store, input logic [2:0] f3,
                                              input logic [31:0] data);
        int unsigned n, d;
        if (!is_store) return 32'd0;
        n = ref_bytes(f3);
        d = data;
        if (n == 1) return (d % 256) * 32'h0101_0101;
        if (n == 2) return (d % 65536) * 32'h0001_0001;
        return data;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] rd, input logic rw, input logic flush);
        ex_valid      = 1'b1;
        ex_flush      = flush;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_funct3     = f3;
        ex_alu_out    = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_flush      = 1'b0;
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_write  = 1'($urandom_range(0, 1));
        ex_funct3     = 3'($urandom_range(0, 7));
        ex_alu_out    = $urandom;
        ex_store_data = $urandom;
        ex_rd         = 5'($urandom_range(0, 31));
        ex_reg_write  = 1'b1;
    endtask

    // Runs one instruction from IDLE to the end of its writeback pulse; starts and ends
    // just after a rising edge.
    task automatic run_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rw, input int waits,
                          input logic [31:0] rdata);
        logic        is_mem;
        logic        bad;
        int unsigned k;
        is_mem = rd_en | wr_en;
        bad    = is_mem && ref_illegal(f3, addr);
        k      = 32'(addr) % 4;
        drive_op(rd_en, wr_en, f3, addr, sdata, rd, rw, 1'b0);
        tick();
        clear_ex();
        @(negedge clk);
        if (!is_mem) begin
            chk("pt_valid", 32'(wb_valid), 32'd1);
            chk("pt_data", wb_data, addr);
            chk("pt_rd", 32'(wb_rd), 32'(rd));
            chk("pt_rw", 32'(wb_reg_write), 32'(rw));
            chk("pt_req", 32'(dmem_bus.dmem_req), 32'd0);
            chk("pt_err", 32'(mem_err), 32'd0);
        end else if (bad) begin
            chk("err_pulse", 32'(mem_err), 32'd1);
            chk("err_valid", 32'(wb_valid), 32'd1);
            chk("err_rw", 32'(wb_reg_write), 32'd0);
            chk("err_req", 32'(dmem_bus.dmem_req), 32'd0);
            chk("err_stall", 32'(stall), 32'd0);
        end else begin
            chk("acc_req", 32'(dmem_bus.dmem_req), 32'd1);
            chk("acc_we", 32'(dmem_bus.dmem_we), 32'(wr_en));
            chk("acc_addr", dmem_bus.dmem_addr, addr & 32'hFFFF_FFFC);
            chk("acc_be", 32'(dmem_bus.dmem_be), ref_be(wr_en, f3, k));
            chk("acc_wdata", dmem_bus.dmem_wdata, ref_wdata(wr_en, f3, sdata));
            chk("acc_stall", 32'(stall), 32'd1);
            chk("acc_wbv", 32'(wb_valid), 32'd0);
            for (int i = 0; i < waits; i++) begin
                tick();
                @(negedge clk);
                chk("wait_stall", 32'(stall), 32'd1);
                chk("wait_req", 32'(dmem_bus.dmem_req), 32'd1);
                chk("wait_addr", dmem_bus.dmem_addr, addr & 32'hFFFF_FFFC);
                chk("wait_be", 32'(dmem_bus.dmem_be), ref_be(wr_en, f3, k));
                chk("wait_wbv", 32'(wb_valid), 32'd0);
            end
            dmem_bus.dmem_ack   = 1'b1;
            dmem_bus.dmem_rdata = rdata;
            tick();
            dmem_bus.dmem_ack   = 1'b0;
            dmem_bus.dmem_rdata = $urandom;
            @(negedge clk);
            chk("done_valid", 32'(wb_valid), 32'd1);
            chk("done_req", 32'(dmem_bus.dmem_req), 32'd0);
            chk("done_stall", 32'(stall), 32'd0);
            chk("done_err", 32'(mem_err), 32'd0);
            if (wr_en) begin
                chk("st_rw", 32'(wb_reg_write), 32'd0);
            end else begin
                chk("ld_data", wb_data, ref_load(f3, k, rdata));
                chk("ld_rw", 32'(wb_reg_write), 32'(rw));
                chk("ld_rd", 32'(wb_rd), 32'(rd));
            end
        end
        tick();
        @(negedge clk);
        chk("pulse_end", 32'(wb_valid), 32'd0);
        chk("pulse_rw", 32'(wb_reg_write), 32'd0);
        chk("pulse_err", 32'(mem_err), 32'd0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        clear_ex();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("rst_addr", dmem_bus.dmem_addr, 32'd0);
        chk("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
        chk("rst_be", 32'(dmem_bus.dmem_be), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_wbrd", 32'(wb_rd), 32'd0);
        chk("rst_wbrw", 32'(wb_reg_write), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Pass-through
        run_op(1'b0, 1'b0, F3_W, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        chk("pt_hold", wb_data, 32'h0000_1234);

        // Byte store at offset 3 with three wait cycles
        run_op(1'b0, 1'b1, F3_B, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 1'b0, 3, 32'h0);

        // Loads from a fixed word
        run_op(1'b1, 1'b0, F3_B, 32'h0000_0202, 32'h0, 5'd1, 1'b1, 1, 32'h80FF_7F01);
        chk("lb_const", wb_data, 32'hFFFF_FFFF);
        run_op(1'b1, 1'b0, F3_BU, 32'h0000_0202, 32'h0, 5'd2, 1'b1, 0, 32'h80FF_7F01);
        chk("lbu_const", wb_data, 32'h0000_00FF);
        run_op(1'b1, 1'b0, F3_H, 32'h0000_0202, 32'h0, 5'd3, 1'b1, 2, 32'h80FF_7F01);
        chk("lh_const", wb_data, 32'hFFFF_80FF);
        run_op(1'b1, 1'b0, F3_HU, 32'h0000_0200, 32'h0, 5'd4, 1'b1, 0, 32'h80FF_7F01);
        chk("lhu_const", wb_data, 32'h0000_7F01);
        run_op(1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0, 5'd6, 1'b1, 1, 32'h80FF_7F01);
        chk("lw_const", wb_data, 32'h80FF_7F01);

        // Misaligned accesses
        run_op(1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 0, 32'h0);
        run_op(1'b0, 1'b1, F3_H, 32'h0000_0103, 32'h1234_5678, 5'd0, 1'b0, 0, 32'h0);

        // Flushed load is dropped
        drive_op(1'b1, 1'b0, F3_W, 32'h0000_0500, 32'h0, 5'd8, 1'b1, 1'b1);
        tick();
        clear_ex();
        @(negedge clk);
        chk("flush_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("flush_wbv", 32'(wb_valid), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        tick();

        // Instruction held during ACCESS is taken exactly once after the load completes
        drive_op(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0, 5'd7, 1'b1, 1'b0);
        tick();
        drive_op(1'b0, 1'b0, F3_W, 32'h0000_CAFE, 32'h0, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        chk("hold_req", 32'(dmem_bus.dmem_req), 32'd1);
        chk("hold_wbv0", 32'(wb_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("hold_stall", 32'(stall), 32'd1);
        chk("hold_wbv1", 32'(wb_valid), 32'd0);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h1234_5678;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("hold_ld_v", 32'(wb_valid), 32'd1);
        chk("hold_ld_d", wb_data, 32'h1234_5678);
        chk("hold_ld_rd", 32'(wb_rd), 32'd7);
        tick();
        clear_ex();
        @(negedge clk);
        chk("hold_pt_v", 32'(wb_valid), 32'd1);
        chk("hold_pt_d", wb_data, 32'h0000_CAFE);
        chk("hold_pt_rd", 32'(wb_rd), 32'd9);
        tick();
        @(negedge clk);
        chk("hold_once", 32'(wb_valid), 32'd0);
        tick();

        // Reset in the middle of an access
        drive_op(1'b1, 1'b0, F3_W, 32'h0000_0400, 32'h0, 5'd3, 1'b1, 1'b0);
        tick();
        clear_ex();
        @(negedge clk);
        chk("rma_req1", 32'(dmem_bus.dmem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rma_req0", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rma_stall", 32'(stall), 32'd0);
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("rma_stray", 32'(wb_valid), 32'd0);
        chk("rma_req2", 32'(dmem_bus.dmem_req), 32'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int          sel;
            logic [2:0]  f3;
            logic [31:0] addr;
            sel  = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            if (sel == 0)
                run_op(1'b0, 1'b0, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), 0, 32'h0);
            else if (sel == 1)
                run_op(1'b1, 1'b0, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
            else
                run_op(1'b0, 1'b1, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), 32'h0);
            if ($urandom_range(0, 7) == 0) begin
                dmem_bus.dmem_ack = 1'b1;
                tick();
                dmem_bus.dmem_ack = 1'b0;
                @(negedge clk);
                chk("idle_ack_wbv", 32'(wb_valid), 32'd0);
                chk("idle_ack_stall", 32'(stall), 32'd0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
